// File: rtl/pci_pkg.sv
// Constants and types shared by the PCI master, its write buffer and any target model.
package pci_pkg;

  localparam int          PCI_MAX_LEN        = 8;
  localparam int          PCI_DEVSEL_TIMEOUT = 5;
  localparam logic [3:0]  PCI_CMD_READ       = 4'b0110;
  localparam logic [3:0]  PCI_CMD_WRITE      = 4'b0111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  function automatic logic len_ok(input logic [3:0] len, input logic [3:0] max_len);
    return (len != 4'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/pci_wbuf.sv
// Burst write buffer: one synchronous write port, one asynchronous read port.
module pci_wbuf
  import pci_pkg::*;
#(
  parameter int DEPTH = PCI_MAX_LEN
) (
  input  logic        CLK,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [2:0]  raddr,
  output logic [31:0] rdata
);

  // Contents deliberately have no reset so loaded words survive a bus reset.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pci_master.sv
// PCI bus master: single-address bursts of memory read/write with DEVSEL# timeout.
module pci_master
  import pci_pkg::*;
#(
  parameter int         DEVSEL_TIMEOUT = PCI_DEVSEL_TIMEOUT,
  parameter int         MAX_LEN        = PCI_MAX_LEN,
  parameter logic [3:0] CMD_READ       = PCI_CMD_READ,
  parameter logic [3:0] CMD_WRITE      = PCI_CMD_WRITE
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [3:0]  req_be,
  input  logic        wbuf_we,
  input  logic [2:0]  wbuf_addr,
  input  logic [31:0] wbuf_data,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        abort,
  output logic        FRAME,
  output logic        IRDY,
  output logic [3:0]  CBE,
  inout  wire  [31:0] BUS,
  input  logic        TRDY,
  input  logic        DEVSEL
);

  localparam logic [3:0] MAX_LEN_W = 4'(MAX_LEN);
  localparam logic [7:0] TIMEOUT_W = 8'(DEVSEL_TIMEOUT);

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [3:0]  cmd_reg;
  logic [3:0]  be_reg;
  logic [3:0]  rem_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  dcnt_reg;
  logic        dseen_reg;
  logic        drive_reg;
  logic        frame_reg;
  logic        irdy_reg;
  logic [3:0]  cbe_reg;
  logic [31:0] rdata_reg;
  logic        rvalid_reg;
  logic        done_reg;
  logic        abort_reg;

  logic [31:0] wbuf_word;
  logic        is_write;
  logic        xfer;
  logic        devsel_ok;
  logic        cmd_ok;

  pci_wbuf #(.DEPTH(MAX_LEN)) u_wbuf (
    .CLK   (CLK),
    .we    (wbuf_we),
    .waddr (wbuf_addr),
    .wdata (wbuf_data),
    .raddr (idx_reg),
    .rdata (wbuf_word)
  );

  assign is_write  = (cmd_reg == CMD_WRITE);
  assign cmd_ok    = (req_cmd == CMD_READ) || (req_cmd == CMD_WRITE);
  assign xfer      = (state_reg == DATA) && !irdy_reg && !TRDY;
  assign devsel_ok = dseen_reg || !DEVSEL;

  // Write data is read asynchronously so a buffer update lands on the bus before its transfer.
  assign BUS = drive_reg ? ((state_reg == DATA) ? wbuf_word : addr_reg) : 'z;

  assign busy        = (state_reg != IDLE);
  assign rdata       = rdata_reg;
  assign rdata_valid = rvalid_reg;
  assign done        = done_reg;
  assign abort       = abort_reg;
  assign FRAME       = frame_reg;
  assign IRDY        = irdy_reg;
  assign CBE         = cbe_reg;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      cmd_reg    <= '0;
      be_reg     <= '0;
      rem_reg    <= '0;
      idx_reg    <= '0;
      dcnt_reg   <= '0;
      dseen_reg  <= 1'b0;
      drive_reg  <= 1'b0;
      frame_reg  <= 1'b1;
      irdy_reg   <= 1'b1;
      cbe_reg    <= '0;
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
      done_reg   <= 1'b0;
      abort_reg  <= 1'b0;
    end else begin
      rvalid_reg <= 1'b0;
      done_reg   <= 1'b0;
      abort_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req && cmd_ok && len_ok(req_len, MAX_LEN_W)) begin
            state_reg <= ADDR;
            addr_reg  <= req_addr;
            cmd_reg   <= req_cmd;
            be_reg    <= req_be;
            rem_reg   <= req_len;
            idx_reg   <= '0;
            dcnt_reg  <= '0;
            dseen_reg <= 1'b0;
            frame_reg <= 1'b0;
            irdy_reg  <= 1'b1;
            cbe_reg   <= req_cmd;
            drive_reg <= 1'b1;
          end
        end
        ADDR: begin
          state_reg <= DATA;
          irdy_reg  <= 1'b0;
          cbe_reg   <= be_reg;
          frame_reg <= (rem_reg == 4'd1);
          // Reads release the bus here so the target gets a turnaround cycle.
          drive_reg <= is_write;
          if (!DEVSEL) begin
            dseen_reg <= 1'b1;
          end else begin
            dcnt_reg <= 8'd1;
          end
        end
        DATA: begin
          if (!dseen_reg) begin
            if (!DEVSEL) begin
              dseen_reg <= 1'b1;
            end else begin
              dcnt_reg <= dcnt_reg + 8'd1;
            end
          end
          if (xfer) begin
            rem_reg <= rem_reg - 4'd1;
            idx_reg <= idx_reg + 3'd1;
            if (!is_write) begin
              rdata_reg  <= BUS;
              rvalid_reg <= 1'b1;
            end
            if (rem_reg == 4'd1) begin
              state_reg <= DONE;
              frame_reg <= 1'b1;
              irdy_reg  <= 1'b1;
              drive_reg <= 1'b0;
              done_reg  <= 1'b1;
            end else if (rem_reg == 4'd2) begin
              frame_reg <= 1'b1;
            end
          end else if (!devsel_ok && (dcnt_reg + 8'd1 >= TIMEOUT_W)) begin
            state_reg <= ABORT;
            frame_reg <= 1'b1;
            irdy_reg  <= 1'b1;
            drive_reg <= 1'b0;
            abort_reg <= 1'b1;
          end
        end
        DONE, ABORT: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_master.sv
// Self-checking bench for pci_master: directed scenarios plus randomized bursts vs a target/transfer model.
module tb_pci_master;
  import pci_pkg::*;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  req_cmd;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [3:0]  req_be;
  logic        wbuf_we;
  logic [2:0]  wbuf_addr;
  logic [31:0] wbuf_data;
  logic        busy;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        abort;
  logic        FRAME;
  logic        IRDY;
  logic [3:0]  CBE;
  wire  [31:0] BUS;
  logic        TRDY;
  logic        DEVSEL;

  logic        tgt_oe;
  logic [31:0] tgt_data;
  logic [31:0] wmem [8];

  int vectors = 0;
  int miscompares = 0;

  assign BUS = tgt_oe ? tgt_data : 'z;

  always #5 CLK = ~CLK;

  pci_master dut (
    .CLK         (CLK),
    .reset       (reset),
    .req         (req),
    .req_cmd     (req_cmd),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_be      (req_be),
    .wbuf_we     (wbuf_we),
    .wbuf_addr   (wbuf_addr),
    .wbuf_data   (wbuf_data),
    .busy        (busy),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .abort       (abort),
    .FRAME       (FRAME),
    .IRDY        (IRDY),
    .CBE         (CBE),
    .BUS         (BUS),
    .TRDY        (TRDY),
    .DEVSEL      (DEVSEL)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Released-bus probe: the target drives zero, so any master drive shows up as a mismatch.
  task automatic chk_released(input string tag);
    tgt_oe   = 1'b1;
    tgt_data = 32'h0;
    #1;
    chk(tag, BUS, 32'h0);
  endtask

  task automatic load_wbuf();
    for (int i = 0; i < 8; i++) begin
      wbuf_we   = 1'b1;
      wbuf_addr = 3'(i);
      wbuf_data = $urandom;
      tick();
      wmem[i] = wbuf_data;
    end
    wbuf_we = 1'b0;
  endtask

  task automatic illegal_req(input logic [3:0] cmd, input logic [3:0] len);
    req = 1'b1; req_cmd = cmd; req_len = len; req_addr = $urandom; req_be = 4'hF;
    tick();
    req = 1'b0;
    chk("illegal_busy", {31'b0, busy}, 32'd0);
    chk("illegal_frame", {31'b0, FRAME}, 32'd1);
    tick();
    chk("illegal_busy2", {31'b0, busy}, 32'd0);
  endtask

  // dsel_at: first cycle after ADDR with DEVSEL# low (0 = never); wfix: wait states per word (-1 = random)
  task automatic burst(input logic [3:0] cmd, input logic [31:0] addr, input int len,
                       input int dsel_at, input int wfix, input bit seq, input int rst_word);
    bit          is_rd, xfer, fin, pend_rv, pend_w;
    int          done_words, waits, pw_idx;
    logic [31:0] pend_rd, pw_data;
    logic [3:0]  be;
    is_rd = (cmd == PCI_CMD_READ);
    be = 4'($urandom);
    fin = 1'b0; pend_rv = 1'b0; pend_w = 1'b0; pend_rd = '0;
    done_words = 0;
    waits = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
    req = 1'b1; req_cmd = cmd; req_addr = addr; req_len = 4'(len); req_be = be;
    tgt_oe = 1'b0; DEVSEL = 1'b1; TRDY = 1'b1;
    tick();
    req = 1'b0;
    chk("addr_frame", {31'b0, FRAME}, 32'd0);
    chk("addr_irdy", {31'b0, IRDY}, 32'd1);
    chk("addr_cbe", {28'b0, CBE}, {28'b0, cmd});
    chk("addr_bus", BUS, addr);
    chk("addr_busy", {31'b0, busy}, 32'd1);
    tick();
    for (int ck = 1; ck <= 200 && !fin; ck++) begin
      if (dsel_at == 0 && ck == PCI_DEVSEL_TIMEOUT) begin
        chk("abort_pulse", {31'b0, abort}, 32'd1);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_frame", {31'b0, FRAME}, 32'd1);
        chk("abort_irdy", {31'b0, IRDY}, 32'd1);
        chk("abort_rvalid", {31'b0, rdata_valid}, 32'd0);
        chk_released("abort_bus");
        tick();
        chk("abort_end", {31'b0, abort}, 32'd0);
        chk("abort_idle", {31'b0, busy}, 32'd0);
        chk("abort_nodone", {31'b0, done}, 32'd0);
        tgt_oe = 1'b0;
        fin = 1'b1;
      end else begin
        chk("data_irdy", {31'b0, IRDY}, 32'd0);
        chk("data_frame", {31'b0, FRAME}, (len - done_words == 1) ? 32'd1 : 32'd0);
        chk("data_cbe", {28'b0, CBE}, {28'b0, be});
        chk("data_flags", {29'b0, busy, done, abort}, 32'd4);
        chk("data_rvalid", {31'b0, rdata_valid}, {31'b0, pend_rv});
        if (pend_rv) chk("data_rdata", rdata, pend_rd);
        DEVSEL = (dsel_at != 0 && ck >= dsel_at) ? 1'b0 : 1'b1;
        xfer = 1'b0; TRDY = 1'b1;
        if (!DEVSEL) begin
          if (waits > 0) waits--;
          else begin xfer = 1'b1; TRDY = 1'b0; end
        end
        if (is_rd) begin
          tgt_oe = 1'b1;
          tgt_data = xfer ? (seq ? 32'(done_words) : $urandom) : 32'h0;
          #1;
          chk("rd_bus", BUS, tgt_data);
        end else begin
          tgt_oe = 1'b0;
          #1;
          chk("wr_bus", BUS, wmem[done_words % 8]);
        end
        if (rst_word >= 0 && done_words == rst_word) begin
          reset = 1'b0;
          tick();
          chk("rst_frame", {31'b0, FRAME}, 32'd1);
          chk("rst_irdy", {31'b0, IRDY}, 32'd1);
          chk("rst_flags", {28'b0, busy, done, abort, rdata_valid}, 32'd0);
          chk_released("rst_bus");
          reset = 1'b1; tgt_oe = 1'b0; DEVSEL = 1'b1; TRDY = 1'b1;
          tick();
          fin = 1'b1;
        end else begin
          if (!is_rd && $urandom_range(0, 3) == 0) begin
            pend_w = 1'b1; pw_idx = (done_words + 1) % 8; pw_data = $urandom;
            wbuf_we = 1'b1; wbuf_addr = 3'(pw_idx); wbuf_data = pw_data;
          end
          pend_rv = is_rd && xfer;
          pend_rd = tgt_data;
          if (xfer) begin
            done_words++;
            waits = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
          end
          tick();
          wbuf_we = 1'b0;
          if (pend_w) begin wmem[pw_idx] = pw_data; pend_w = 1'b0; end
          if (done_words == len) begin
            chk("done_pulse", {31'b0, done}, 32'd1);
            chk("done_abort", {31'b0, abort}, 32'd0);
            chk("done_frame", {31'b0, FRAME}, 32'd1);
            chk("done_irdy", {31'b0, IRDY}, 32'd1);
            chk("done_rvalid", {31'b0, rdata_valid}, {31'b0, pend_rv});
            if (pend_rv) chk("done_rdata", rdata, pend_rd);
            DEVSEL = 1'b1; TRDY = 1'b1;
            chk_released("done_bus");
            tick();
            chk("idle_flags", {28'b0, busy, done, abort, rdata_valid}, 32'd0);
            tgt_oe = 1'b0;
            fin = 1'b1;
          end
        end
      end
    end
    if (!fin) begin
      vectors++;
      miscompares++;
      $error("FAIL burst_bound observed=%0d words expected=%0d words", done_words, len);
      reset = 1'b0; tgt_oe = 1'b0; DEVSEL = 1'b1; TRDY = 1'b1;
      tick();
      reset = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; req_cmd = '0; req_addr = '0; req_len = '0; req_be = '0;
    wbuf_we = 1'b0; wbuf_addr = '0; wbuf_data = '0; TRDY = 1'b1; DEVSEL = 1'b1;
    tgt_oe = 1'b0; tgt_data = '0;
    tick(); tick();
    chk("rst_frame0", {31'b0, FRAME}, 32'd1);
    chk("rst_irdy0", {31'b0, IRDY}, 32'd1);
    chk("rst_cbe0", {28'b0, CBE}, 32'd0);
    chk("rst_flags0", {28'b0, busy, done, abort, rdata_valid}, 32'd0);
    chk_released("rst_bus0");
    tgt_oe = 1'b0;
    reset = 1'b1;
    tick();
    load_wbuf();

    // Write of three buffered words, target ready from the second clock after ADDR.
    burst(PCI_CMD_WRITE, 32'h1111_1110, 3, 2, 0, 1'b0, -1);
    // Eight-word read returning 0..7.
    burst(PCI_CMD_READ, 32'h1111_1110, 8, 1, 0, 1'b1, -1);
    // Nobody claims the cycle.
    burst(PCI_CMD_READ, 32'h2222_0000, 4, 0, 0, 1'b0, -1);
    burst(PCI_CMD_WRITE, 32'h2222_0040, 2, 0, 0, 1'b0, -1);
    // Three wait states ahead of each word.
    burst(PCI_CMD_READ, 32'h3333_0000, 2, 1, 3, 1'b0, -1);
    // Reset in the second data phase of a four-word write.
    burst(PCI_CMD_WRITE, 32'h4444_0000, 4, 1, 0, 1'b0, 1);
    // Requests that must be ignored.
    illegal_req(PCI_CMD_READ, 4'd0);
    illegal_req(4'b0000, 4'd3);
    illegal_req(PCI_CMD_WRITE, 4'd9);
    burst(PCI_CMD_WRITE, 32'h5555_0000, 1, 1, 0, 1'b0, -1);

    for (int n = 0; n < 24; n++) begin
      if (n % 6 == 0) load_wbuf();
      burst(($urandom_range(0, 1) == 1) ? PCI_CMD_READ : PCI_CMD_WRITE, $urandom,
            int'($urandom_range(1, 8)),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)),
            -1, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
